ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter (inhibit, request, send, ack).
// Define PS2_TX_TIMEOUT_EN to add a per-frame watchdog of TIMEOUT_CYCLES.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    sh_q, sh_d;
  logic          nack_q, nack_d;
  logic          clk_oe_d, dat_oe_d;

  logic clk_m, clk_s, clk_p;
  logic dat_m, dat_s;
  logic fall;

  // Idle bus is high, so the synchronizers come out of reset at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_m <= 1'b1;
      clk_s <= 1'b1;
      clk_p <= 1'b1;
      dat_m <= 1'b1;
      dat_s <= 1'b1;
    end else begin
      clk_m <= ps2_clk_in;
      clk_s <= clk_m;
      clk_p <= clk_s;
      dat_m <= ps2_dat_in;
      dat_s <= dat_m;
    end
  end

  assign fall = clk_p & ~clk_s;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_q;
  logic          wd_run;
  logic          wd_hit;

  assign wd_run = (state_q == SEND) || (state_q == ACK) ||
                  (state_q == WAIT_IDLE);
  assign wd_hit = wd_run && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (!wd_run || wd_hit) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  // Parameter kept so both builds share one instantiation.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  always_comb begin
    state_d  = state_q;
    inh_d    = inh_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    nack_d   = nack_q;
    dat_oe_d = ps2_dat_oe;
    tx_done  = 1'b0;
    tx_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          sh_d    = {~^tx_data, tx_data};
          inh_d   = '0;
          bit_d   = '0;
          nack_d  = 1'b0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        dat_oe_d = 1'b0;
        if (inh_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          state_d  = REQ;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      REQ: begin
        dat_oe_d = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (fall) begin
          if (bit_q == 4'd9) begin
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end else begin
            dat_oe_d = ~sh_q[0];
            sh_d     = {1'b1, sh_q[8:1]};
            bit_d    = bit_q + 4'd1;
          end
        end
      end
      ACK: begin
        dat_oe_d = 1'b0;
        if (fall) begin
          nack_d  = dat_s;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        dat_oe_d = 1'b0;
        if (clk_s && dat_s) begin
          tx_done = 1'b1;
          tx_err  = nack_q;
          state_d = IDLE;
        end
      end
      default: begin
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (wd_hit) begin
      dat_oe_d = 1'b0;
      tx_done  = 1'b1;
      tx_err   = 1'b1;
      state_d  = IDLE;
    end
`endif
    clk_oe_d = (state_d == INHIBIT) || (state_d == REQ);
  end

  // Line drivers are registered so the open-collector pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inh_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      nack_q     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_q      <= inh_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      nack_q     <= nack_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
    end
  end

  assign tx_ready = (state_q == IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: scoreboard bench for ps2_tx with a behavioural PS/2 device.
// Build with PS2_TX_TIMEOUT_EN to cover the watchdog path.
module tb_ps2_tx;

  localparam int INH = 100;
  localparam int TO  = 20000;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       dev_clk_lo;
  logic       dev_dat_lo;

  int n_chk  = 0;
  int n_fail = 0;

  int   done_cnt = 0;
  int   orphan   = 0;
  logic last_err = 1'b0;
  int   win_len  = 0;
  int   dat_at   = 0;
  int   last_win = 0;
  int   last_dat = 0;

  logic [9:0] exp_q[$];

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #10 clk = ~clk;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_lo);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_lo);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame: stop, odd parity, data LSB first.
  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready)
      exp_q.push_back({1'b1, ~^tx_data, tx_data});
  end

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt++;
      last_err = tx_err;
    end
    if (tx_err && !tx_done) orphan++;
    if (ps2_clk_oe) begin
      win_len++;
      if (ps2_dat_oe && dat_at == 0) dat_at = win_len;
    end else if (win_len != 0) begin
      last_win = win_len;
      last_dat = dat_at;
      win_len  = 0;
      dat_at   = 0;
    end
  end

  task automatic sb_check(input string tag, input logic [9:0] got);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {22'd0, got}, {22'd0, e});
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 30000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Device: waits for the start bit, clocks npulse bits, then the ack slot.
  task automatic dev_frame(input int half, input int npulse,
                           input bit ack, output logic [9:0] bits,
                           output bit ok);
    int n;
    n    = 0;
    ok   = 1'b1;
    bits = '0;
    while (!(ps2_clk_in && !ps2_dat_in) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50000) begin
      ok = 1'b0;
      return;
    end
    #(half);
    for (int i = 0; i < npulse; i++) begin
      dev_clk_lo = 1'b1;
      #(half);
      dev_clk_lo = 1'b0;
      bits[i] = ps2_dat_in;
      #(half);
    end
    if (npulse == 10) begin
      if (ack) dev_dat_lo = 1'b1;
      #(half / 2);
      dev_clk_lo = 1'b1;
      #(half);
      dev_clk_lo = 1'b0;
      #(half);
      dev_dat_lo = 1'b0;
    end
  endtask

  initial begin
    logic [9:0] rx;
    bit         ok;
    int         base;

    rst        = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = '0;
    dev_clk_lo = 1'b0;
    dev_dat_lo = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, tx_ready}, 1);
    chk("rst_done", {31'd0, tx_done}, 0);
    chk("rst_err", {31'd0, tx_err}, 0);

    base = done_cnt;
    send_byte(8'hED);
    dev_frame(10000, 10, 1'b1, rx, ok);
    chk("ed_dev_ok", {31'd0, ok}, 1);
    wait_done(base);
    chk("ed_bits", {22'd0, rx}, 32'h3ED);
    sb_check("ed_sb", rx);
    chk("ed_done", done_cnt - base, 1);
    chk("ed_err", {31'd0, last_err}, 0);
    @(negedge clk);
    chk("ed_ready", {31'd0, tx_ready}, 1);
    chk("inh_len", last_win, INH + 1);
    chk("inh_dat_rise", last_dat, INH + 1);

    base = done_cnt;
    send_byte(8'h55);
    dev_frame(2000, 10, 1'b0, rx, ok);
    chk("nack_dev_ok", {31'd0, ok}, 1);
    wait_done(base);
    sb_check("nack_sb", rx);
    chk("nack_done", done_cnt - base, 1);
    chk("nack_err", {31'd0, last_err}, 1);

    base = done_cnt;
    send_byte(8'hA5);
    dev_frame(2000, 4, 1'b1, rx, ok);
    chk("mid_dev_ok", {31'd0, ok}, 1);
    chk("mid_dat_oe", {31'd0, ps2_dat_oe}, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    chk("mid_rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_ready", {31'd0, tx_ready}, 1);
    chk("mid_no_done", done_cnt - base, 0);

    base = done_cnt;
    send_byte(8'hF4);
    dev_frame(2000, 10, 1'b1, rx, ok);
    chk("f4_dev_ok", {31'd0, ok}, 1);
    wait_done(base);
    chk("f4_bits", {22'd0, rx}, 32'h2F4);
    sb_check("f4_sb", rx);
    chk("f4_done", done_cnt - base, 1);
    chk("f4_err", {31'd0, last_err}, 0);
    chk("f4_inh_len", last_win, INH + 1);

    base = done_cnt;
    send_byte(8'hED);
    fork
      dev_frame(2000, 10, 1'b1, rx, ok);
      begin
        #10000;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    chk("busy_dev_ok", {31'd0, ok}, 1);
    wait_done(base);
    repeat (200) @(negedge clk);
    chk("busy_bits", {22'd0, rx}, 32'h3ED);
    sb_check("busy_sb", rx);
    chk("busy_q_left", exp_q.size(), 0);
    chk("busy_done", done_cnt - base, 1);
    chk("busy_ready", {31'd0, tx_ready}, 1);

    base = done_cnt;
    send_byte(8'h12);
    wait_done(base);
    @(negedge clk);
`ifdef PS2_TX_TIMEOUT_EN
    chk("to_done", done_cnt - base, 1);
    chk("to_err", {31'd0, last_err}, 1);
    chk("to_clk_oe", {31'd0, ps2_clk_oe}, 0);
    chk("to_dat_oe", {31'd0, ps2_dat_oe}, 0);
    chk("to_ready", {31'd0, tx_ready}, 1);
`else
    chk("to_no_done", done_cnt - base, 0);
    chk("to_busy", {31'd0, tx_ready}, 0);
    chk("to_start_bit", {31'd0, ps2_dat_oe}, 1);
    chk("to_clk_rel", {31'd0, ps2_clk_oe}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
    exp_q.delete();
    chk("err_orphan", orphan, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
